// File: rtl/tagged_mem_model.sv
`timescale 1ns/1ps
// tagged_mem_model: tagged word memory with configurable load latency,
// a bounded outstanding-load window (busy = response 0) and wrapping tags.
// Ports:
//   clk, rst (async, active-low)
//   proc2mem_addr/data/command : byte address, store data, 0 NONE 1 LOAD 2 STORE
//   mem2proc_response          : tag of the command accepted this cycle, else 0
//   mem2proc_data/tag          : registered load completion (tag 0 = none)
//   mem_align_err              : sticky misalignment flag (MEM_ALIGN_CHECK_EN only)
// Optional feature macro: MEM_ALIGN_CHECK_EN
module tagged_mem_model #(
  parameter int DATA_W          = 32,
  parameter int ADDR_W          = 32,
  parameter int DEPTH_WORDS     = 16384,
  parameter int LATENCY         = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int TAG_W           = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] proc2mem_addr,
  input  logic [DATA_W-1:0] proc2mem_data,
  input  logic [1:0]        proc2mem_command,
  output logic [TAG_W-1:0]  mem2proc_response,
  output logic [DATA_W-1:0] mem2proc_data,
  output logic [TAG_W-1:0]  mem2proc_tag
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic              mem_align_err
`endif
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [TAG_W-1:0] TAG_MAX = '1;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;

  logic [DATA_W-1:0] unified_memory [0:DEPTH_WORDS-1];

  logic [TAG_W-1:0]  r_next_tag;
  logic [CNT_W-1:0]  r_outstanding;
  // Tag 0 in a stage marks an empty slot.
  logic [TAG_W-1:0]  r_pipe_tag  [0:LATENCY-1];
  logic [DATA_W-1:0] r_pipe_data [0:LATENCY-1];

  logic [IDX_W-1:0]  w_idx;
  logic              w_misalign;
  logic              w_is_load;
  logic              w_is_store;
  logic              w_cmpl;
  logic              w_room;
  logic              w_acc_load;
  logic              w_acc_store;
  logic              w_accept;
  logic [TAG_W-1:0]  w_tag_inc;
  logic              w_unused;

  assign w_idx    = proc2mem_addr[IDX_W+1:2];
  assign w_unused = ^{proc2mem_addr[ADDR_W-1:IDX_W+2],
                      proc2mem_addr[1:0]};

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = proc2mem_addr[1:0] != 2'b00;
`else
  assign w_misalign = 1'b0;
`endif

  assign w_is_load  = rst && !w_misalign
                   && (proc2mem_command == CMD_LOAD);
  assign w_is_store = rst && !w_misalign
                   && (proc2mem_command == CMD_STORE);

  // The load on the output retires at this edge, freeing its slot.
  assign w_cmpl = r_pipe_tag[LATENCY-1] != '0;
  assign w_room = (r_outstanding < CNT_W'(MAX_OUTSTANDING))
               || w_cmpl;

  assign w_acc_load  = w_is_load && w_room;
  assign w_acc_store = w_is_store;
  assign w_accept    = w_acc_load || w_acc_store;

  assign w_tag_inc = (r_next_tag == TAG_MAX)
                   ? TAG_W'(1)
                   : r_next_tag + TAG_W'(1);

  assign mem2proc_response = w_accept ? r_next_tag : '0;
  assign mem2proc_tag      = r_pipe_tag[LATENCY-1];
  assign mem2proc_data     = r_pipe_data[LATENCY-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_next_tag    <= TAG_W'(1);
      r_outstanding <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_pipe_tag[i]  <= '0;
        r_pipe_data[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_next_tag <= w_tag_inc;
      end
      if (w_acc_load && !w_cmpl) begin
        r_outstanding <= r_outstanding + CNT_W'(1);
      end else if (!w_acc_load && w_cmpl) begin
        r_outstanding <= r_outstanding - CNT_W'(1);
      end
      // Data is snapshotted at acceptance, so later stores cannot alter it.
      r_pipe_tag[0]  <= w_acc_load ? r_next_tag : '0;
      r_pipe_data[0] <= w_acc_load ? unified_memory[w_idx] : '0;
      for (int i = 1; i < LATENCY; i++) begin
        r_pipe_tag[i]  <= r_pipe_tag[i-1];
        r_pipe_data[i] <= r_pipe_data[i-1];
      end
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (w_acc_store) begin
      unified_memory[w_idx] <= proc2mem_data;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic r_align_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_align_err <= 1'b0;
    end else if (w_misalign
              && ((proc2mem_command == CMD_LOAD)
               || (proc2mem_command == CMD_STORE))) begin
      r_align_err <= 1'b1;
    end
  end

  assign mem_align_err = r_align_err;
`endif

endmodule

// File: tb/tb_tagged_mem_model.sv
`timescale 1ns/1ps
// Testbench for tagged_mem_model: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_tagged_mem_model;

  localparam int LAT   = 4;
  localparam int MAXO  = 2;
  localparam int TW    = 2;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [1:0]  cmd = '0;

  logic [TW-1:0] resp, tag;
  logic [31:0]   rdata;
  logic [3:0]    resp2, tag2;
  logic [31:0]   rdata2;
`ifdef MEM_ALIGN_CHECK_EN
  logic err, err2;
  bit   o_err;
`endif

  always #5 clk = ~clk;

  tagged_mem_model #(
    .DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(DEPTH),
    .LATENCY(LAT), .MAX_OUTSTANDING(MAXO), .TAG_W(TW)
  ) dut (
    .clk(clk), .rst(rst),
    .proc2mem_addr(addr), .proc2mem_data(wdata),
    .proc2mem_command(cmd),
    .mem2proc_response(resp), .mem2proc_data(rdata),
    .mem2proc_tag(tag)
`ifdef MEM_ALIGN_CHECK_EN
    , .mem_align_err(err)
`endif
  );

  // Full-throughput instance: MAX_OUTSTANDING == LATENCY.
  tagged_mem_model #(
    .DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(DEPTH),
    .LATENCY(2), .MAX_OUTSTANDING(2), .TAG_W(4)
  ) dut2 (
    .clk(clk), .rst(rst),
    .proc2mem_addr(addr), .proc2mem_data(wdata),
    .proc2mem_command(cmd),
    .mem2proc_response(resp2), .mem2proc_data(rdata2),
    .mem2proc_tag(tag2)
`ifdef MEM_ALIGN_CHECK_EN
    , .mem_align_err(err2)
`endif
  );

  typedef struct {
    int          due;
    int          tg;
    logic [31:0] data;
  } ent_t;

  logic [31:0] mmem [0:DEPTH-1];
  ent_t        q[$];
  int          now = 0;
  int          m_next = 1;
  bit          m_err = 0;
  int          m_resp, m_tag;
  logic [31:0] m_data;
  bit          m_err_exp;

  int          o_resp, o_tag, o2_resp, o2_tag;
  logic [31:0] o_data, o2_data;

  int ntests = 0;
  int nfail  = 0;

  // Reference: loads return in cycle now+LAT; window counts loads not yet
  // past their completion cycle.
  task automatic model_step(input logic [1:0] c, input logic [31:0] a,
                            input logic [31:0] d);
    int   idx;
    bit   mis, cmpl;
    ent_t e;
    idx = int'((a >> 2) % DEPTH);
    while (q.size() > 0 && q[0].due < now) void'(q.pop_front());
    cmpl = (q.size() > 0) && (q[0].due == now);
    m_tag  = cmpl ? q[0].tg : 0;
    m_data = cmpl ? q[0].data : 32'h0;
    m_err_exp = m_err;
    m_resp = 0;
    mis = 0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = (c == 2'd1 || c == 2'd2) && (a % 4 != 0);
    if (mis) m_err = 1;
`endif
    if (!mis && c == 2'd2) begin
      mmem[idx] = d;
      m_resp = m_next;
      m_next = m_next % ((1 << TW) - 1) + 1;
    end else if (!mis && c == 2'd1 && (q.size() < MAXO || cmpl)) begin
      e.due = now + LAT;
      e.tg = m_next;
      e.data = mmem[idx];
      q.push_back(e);
      m_resp = m_next;
      m_next = m_next % ((1 << TW) - 1) + 1;
    end
    now++;
  endtask

  task automatic cyc(input logic [1:0] c, input logic [31:0] a,
                     input logic [31:0] d);
    cmd = c;
    addr = a;
    wdata = d;
    #1;
    o_resp  = int'(resp);
    o_tag   = int'(tag);
    o_data  = rdata;
    o2_resp = int'(resp2);
    o2_tag  = int'(tag2);
    o2_data = rdata2;
`ifdef MEM_ALIGN_CHECK_EN
    o_err = err;
`endif
    model_step(c, a, d);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cmd = 2'd0;
    rst = 1'b0;
    q.delete();
    m_next = 1;
    m_err = 0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    cmd = 2'd1;
    rst = 1'b0;
    #1;
    ntests++;
    if (resp !== '0) begin
      nfail++;
      $display("FAIL reset_resp got=%0d exp=0", resp);
    end
    ntests++;
    if (tag !== '0 || rdata !== '0) begin
      nfail++;
      $display("FAIL reset_out got tag=%0d data=%h exp 0/0", tag, rdata);
    end
    ntests++;
    if (tag2 !== '0 || resp2 !== '0) begin
      nfail++;
      $display("FAIL reset_dut2 got tag=%0d resp=%0d exp 0/0", tag2, resp2);
    end
`ifdef MEM_ALIGN_CHECK_EN
    ntests++;
    if (err !== 1'b0) begin
      nfail++;
      $display("FAIL reset_err got=%0d exp=0", err);
    end
`endif
    @(posedge clk);
    #1;
    ntests++;
    if (tag !== '0 || resp !== '0) begin
      nfail++;
      $display("FAIL reset_hold got tag=%0d resp=%0d exp 0/0", tag, resp);
    end
    do_reset();
  endtask

  task automatic init_mem();
    for (int w = 0; w < DEPTH; w++) begin
      cyc(2'd2, 32'(w * 4), (w == 0) ? 32'h13 : $urandom);
      ntests++;
      if (o_resp !== m_resp) begin
        nfail++;
        $display("FAIL init_resp w=%0d got=%0d exp=%0d", w, o_resp, m_resp);
      end
    end
  endtask

  task automatic test_first_load();
    do_reset();
    cyc(2'd1, 32'h0, 32'h0);
    ntests++;
    if (o_resp !== 1) begin
      nfail++;
      $display("FAIL first_resp got=%0d exp=1", o_resp);
    end
    for (int k = 1; k <= 5; k++) begin
      cyc(2'd0, 32'h0, 32'h0);
      ntests++;
      if (o_tag !== ((k == LAT) ? 1 : 0)) begin
        nfail++;
        $display("FAIL first_tag k=%0d got=%0d exp=%0d",
                 k, o_tag, (k == LAT) ? 1 : 0);
      end
      if (k == LAT) begin
        ntests++;
        if (o_data !== 32'h13) begin
          nfail++;
          $display("FAIL first_data got=%h exp=00000013", o_data);
        end
      end
    end
  endtask

  task automatic test_store_load();
    do_reset();
    cyc(2'd2, 32'h40, 32'hDEADBEEF);
    ntests++;
    if (o_resp !== 1) begin
      nfail++;
      $display("FAIL sl_store_resp got=%0d exp=1", o_resp);
    end
    cyc(2'd1, 32'h40, 32'h0);
    ntests++;
    if (o_resp !== 2) begin
      nfail++;
      $display("FAIL sl_load_resp got=%0d exp=2", o_resp);
    end
    cyc(2'd2, 32'h40, 32'h12345678);
    ntests++;
    if (o_resp !== 3) begin
      nfail++;
      $display("FAIL sl_store2_resp got=%0d exp=3", o_resp);
    end
    for (int k = 3; k <= 5; k++) begin
      cyc(2'd0, 32'h0, 32'h0);
      ntests++;
      if (o_tag !== ((k == 5) ? 2 : 0)) begin
        nfail++;
        $display("FAIL sl_tag k=%0d got=%0d", k, o_tag);
      end
    end
    ntests++;
    if (o_data !== 32'hDEADBEEF) begin
      nfail++;
      $display("FAIL sl_snapshot got=%h exp=deadbeef", o_data);
    end
    cyc(2'd1, 32'h40, 32'h0);
    ntests++;
    if (o_resp !== 1) begin
      nfail++;
      $display("FAIL sl_wrap_resp got=%0d exp=1", o_resp);
    end
    for (int k = 1; k <= LAT; k++) cyc(2'd0, 32'h0, 32'h0);
    ntests++;
    if (o_tag !== 1 || o_data !== 32'h12345678) begin
      nfail++;
      $display("FAIL sl_new_data got tag=%0d data=%h exp 1/12345678",
               o_tag, o_data);
    end
  endtask

  task automatic test_backpressure();
    int er [6] = '{1, 2, 0, 0, 3, 1};
    int et [6] = '{0, 0, 0, 0, 1, 2};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      cyc(2'd1, 32'h40, 32'h0);
      ntests++;
      if (o_resp !== er[k] || o_tag !== et[k]) begin
        nfail++;
        $display("FAIL bp k=%0d got resp=%0d tag=%0d exp %0d/%0d",
                 k, o_resp, o_tag, er[k], et[k]);
      end
    end
    for (int k = 0; k < 6; k++) begin
      cyc(2'd0, 32'h0, 32'h0);
      ntests++;
      if (o_tag !== m_tag) begin
        nfail++;
        $display("FAIL bp_drain k=%0d got=%0d exp=%0d", k, o_tag, m_tag);
      end
    end
  endtask

  task automatic test_tag_wrap();
    int er [5] = '{1, 2, 3, 1, 2};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cyc(2'd2, 32'(32'h80 + k * 4), $urandom);
      ntests++;
      if (o_resp !== er[k]) begin
        nfail++;
        $display("FAIL wrap k=%0d got=%0d exp=%0d", k, o_resp, er[k]);
      end
    end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    cyc(2'd1, 32'h0, 32'h0);
    cyc(2'd1, 32'h4, 32'h0);
    cmd = 2'd1;
    rst = 1'b0;
    #1;
    ntests++;
    if (tag !== '0 || rdata !== '0 || resp !== '0) begin
      nfail++;
      $display("FAIL rif_out got tag=%0d data=%h resp=%0d exp 0",
               tag, rdata, resp);
    end
    ntests++;
    if (tag2 !== '0 || rdata2 !== '0 || resp2 !== '0) begin
      nfail++;
      $display("FAIL rif_out2 got tag=%0d data=%h resp=%0d exp 0",
               tag2, rdata2, resp2);
    end
    q.delete();
    m_next = 1;
    m_err = 0;
    @(negedge clk);
    cmd = 2'd0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 6; k++) begin
      cyc(2'd0, 32'h0, 32'h0);
      ntests++;
      if (o_tag !== 0 || o2_tag !== 0) begin
        nfail++;
        $display("FAIL rif_stale k=%0d got tag=%0d tag2=%0d exp 0",
                 k, o_tag, o2_tag);
      end
    end
    cyc(2'd1, 32'h0, 32'h0);
    ntests++;
    if (o_resp !== 1) begin
      nfail++;
      $display("FAIL rif_resp got=%0d exp=1", o_resp);
    end
    for (int k = 1; k <= LAT; k++) cyc(2'd0, 32'h0, 32'h0);
    ntests++;
    if (o_tag !== 1 || o_data !== 32'h13) begin
      nfail++;
      $display("FAIL rif_array got tag=%0d data=%h exp 1/00000013",
               o_tag, o_data);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] old;
    do_reset();
    old = mmem[16];
    cyc(2'd2, 32'h42, 32'hCAFEF00D);
`ifdef MEM_ALIGN_CHECK_EN
    ntests++;
    if (o_resp !== 0) begin
      nfail++;
      $display("FAIL mis_resp got=%0d exp=0", o_resp);
    end
    cyc(2'd1, 32'h40, 32'h0);
    ntests++;
    if (o_resp !== 1 || o_err !== 1'b1) begin
      nfail++;
      $display("FAIL mis_next got resp=%0d err=%0d exp 1/1", o_resp, o_err);
    end
    for (int k = 1; k <= LAT; k++) cyc(2'd0, 32'h0, 32'h0);
    ntests++;
    if (o_tag !== 1 || o_data !== old) begin
      nfail++;
      $display("FAIL mis_nowrite got tag=%0d data=%h exp 1/%h",
               o_tag, o_data, old);
    end
    cyc(2'd1, 32'h41, 32'h0);
    ntests++;
    if (o_resp !== 0 || o_err !== 1'b1) begin
      nfail++;
      $display("FAIL mis_load got resp=%0d err=%0d exp 0/1", o_resp, o_err);
    end
    do_reset();
    cyc(2'd0, 32'h0, 32'h0);
    ntests++;
    if (o_err !== 1'b0) begin
      nfail++;
      $display("FAIL mis_clear got=%0d exp=0", o_err);
    end
`else
    ntests++;
    if (o_resp !== 1) begin
      nfail++;
      $display("FAIL mis_resp got=%0d exp=1", o_resp);
    end
    cyc(2'd1, 32'h40, 32'h0);
    ntests++;
    if (o_resp !== 2) begin
      nfail++;
      $display("FAIL mis_next got=%0d exp=2", o_resp);
    end
    for (int k = 1; k <= LAT; k++) cyc(2'd0, 32'h0, 32'h0);
    ntests++;
    if (o_tag !== 2 || o_data !== 32'hCAFEF00D || old === 32'hCAFEF00D) begin
      nfail++;
      $display("FAIL mis_word got tag=%0d data=%h exp 2/cafef00d",
               o_tag, o_data);
    end
`endif
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cyc(2'd1, 32'(i * 4), 32'h0);
      ntests++;
      if (o2_resp !== i + 1) begin
        nfail++;
        $display("FAIL b2b_resp i=%0d got=%0d exp=%0d", i, o2_resp, i + 1);
      end
      ntests++;
      if (o2_tag !== ((i >= 2) ? i - 1 : 0)) begin
        nfail++;
        $display("FAIL b2b_tag i=%0d got=%0d exp=%0d",
                 i, o2_tag, (i >= 2) ? i - 1 : 0);
      end
      if (i >= 2) begin
        ntests++;
        if (o2_data !== mmem[i-2]) begin
          nfail++;
          $display("FAIL b2b_data i=%0d got=%h exp=%h",
                   i, o2_data, mmem[i-2]);
        end
      end
    end
    for (int k = 0; k < LAT + 2; k++) cyc(2'd0, 32'h0, 32'h0);
  endtask

  task automatic test_random();
    logic [1:0]  c;
    logic [31:0] a;
    int          r;
    for (int n = 0; n < 420; n++) begin
      r = int'($urandom % 8);
      if (n >= 400) c = 2'd0;
      else if (r < 4) c = 2'd1;
      else if (r < 6) c = 2'd2;
      else if (r == 6) c = 2'd0;
      else c = 2'd3;
      a = ($urandom & 32'hFFFF_0000) | (($urandom % 16) << 2);
      if ($urandom % 8 == 0) a = a | ($urandom % 4);
      cyc(c, a, $urandom);
      ntests++;
      if (o_resp !== m_resp) begin
        nfail++;
        $display("FAIL rnd_resp n=%0d got=%0d exp=%0d", n, o_resp, m_resp);
      end
      ntests++;
      if (o_tag !== m_tag) begin
        nfail++;
        $display("FAIL rnd_tag n=%0d got=%0d exp=%0d", n, o_tag, m_tag);
      end
      if (m_tag != 0) begin
        ntests++;
        if (o_data !== m_data) begin
          nfail++;
          $display("FAIL rnd_data n=%0d got=%h exp=%h", n, o_data, m_data);
        end
      end
`ifdef MEM_ALIGN_CHECK_EN
      ntests++;
      if (o_err !== m_err_exp) begin
        nfail++;
        $display("FAIL rnd_err n=%0d got=%0d exp=%0d", n, o_err, m_err_exp);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    init_mem();
    test_first_load();
    test_store_load();
    test_backpressure();
    test_tag_wrap();
    test_reset_inflight();
    test_misalign();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
